// File: rtl/otp_pkg.sv
// Shared types and helpers for the one-time-pad keystream generator.
// The LFSR step works on a wide container so any KEY_W up to OTP_MAX_W can use it.
package otp_pkg;

    localparam int unsigned OTP_MAX_W = 64;
    localparam logic [31:0] POLY_DEFAULT = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WARMUP    = 2'd1,
        RUN       = 2'd2,
        EXHAUSTED = 2'd3
    } otp_state_t;

    // Galois step; upper bits beyond the real width must be zero in both operands.
    function automatic logic [OTP_MAX_W-1:0] lfsr_step(
        input logic [OTP_MAX_W-1:0] s,
        input logic [OTP_MAX_W-1:0] poly
    );
        logic [OTP_MAX_W-1:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ poly;
        end
        return r;
    endfunction

endpackage

// File: rtl/otp_keystream_gen_lfsr.sv
// Galois LFSR register with seed load and step enables.
// A zero seed is replaced by 1 so the register can never lock up at all-zero.
module otp_lfsr
    import otp_pkg::*;
#(
    parameter int unsigned      KEY_W = 32,
    parameter logic [KEY_W-1:0] POLY  = KEY_W'(POLY_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [KEY_W-1:0] seed,
    output logic [KEY_W-1:0] state
);

    logic [KEY_W-1:0] lfsr_q;
    logic [KEY_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? KEY_W'(1) : seed;
        end else if (step) begin
            lfsr_d = KEY_W'(lfsr_step(OTP_MAX_W'(lfsr_q), OTP_MAX_W'(POLY)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/otp_keystream_gen.sv
// One-time-pad word source: seeded LFSR behind a valid/ready port, with warm-up
// discard after each seed and a hard per-seed word budget that forces a rekey.
module otp_keystream_gen
    import otp_pkg::*;
#(
    parameter int unsigned      KEY_W       = 32,
    parameter logic [KEY_W-1:0] POLY        = KEY_W'(POLY_DEFAULT),
    parameter int unsigned      WARMUP      = 16,
    parameter int unsigned      REKEY_LIMIT = 1024,
    parameter int unsigned      CNT_W       = $clog2(REKEY_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [KEY_W-1:0] seed,
    output logic             seed_ready,
    output logic             otp_valid,
    input  logic             otp_ready,
    output logic [KEY_W-1:0] otp,
    output logic [CNT_W-1:0] words_issued,
    output logic             rekey_req,
    output logic             busy
);

    // The local WARMUP parameter hides the enum literal, so states are always scoped.
    localparam int unsigned WU_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    otp_state_t       state_q;
    otp_state_t       state_d;
    logic [CNT_W-1:0] words_q;
    logic [CNT_W-1:0] words_d;
    logic [WU_W-1:0]  wu_q;
    logic [WU_W-1:0]  wu_d;
    logic             lfsr_ld;
    logic             lfsr_adv;
    logic [KEY_W-1:0] lfsr_state;

    otp_lfsr #(
        .KEY_W (KEY_W),
        .POLY  (POLY)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_ld),
        .step  (lfsr_adv),
        .seed  (seed),
        .state (lfsr_state)
    );

    always_comb begin
        state_d  = state_q;
        words_d  = words_q;
        wu_d     = wu_q;
        lfsr_ld  = 1'b0;
        lfsr_adv = 1'b0;
        case (state_q)
            otp_pkg::IDLE, otp_pkg::EXHAUSTED: begin
                if (seed_valid) begin
                    lfsr_ld = 1'b1;
                    words_d = '0;
                    wu_d    = '0;
                    state_d = (WARMUP > 0) ? otp_pkg::WARMUP : otp_pkg::RUN;
                end
            end
            otp_pkg::WARMUP: begin
                lfsr_adv = 1'b1;
                wu_d     = wu_q + WU_W'(1);
                if (wu_q == WU_W'(WARMUP - 1)) begin
                    state_d = otp_pkg::RUN;
                end
            end
            otp_pkg::RUN: begin
                if (otp_ready) begin
                    lfsr_adv = 1'b1;
                    words_d  = words_q + CNT_W'(1);
                    if (words_d == CNT_W'(REKEY_LIMIT)) begin
                        state_d = otp_pkg::EXHAUSTED;
                    end
                end
            end
            default: state_d = otp_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= otp_pkg::IDLE;
            words_q <= '0;
            wu_q    <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            wu_q    <= wu_d;
        end
    end

    // All status outputs decode straight from the state register.
    assign seed_ready   = (state_q == otp_pkg::IDLE) || (state_q == otp_pkg::EXHAUSTED);
    assign otp_valid    = (state_q == otp_pkg::RUN);
    assign busy         = (state_q == otp_pkg::WARMUP);
    assign rekey_req    = (state_q == otp_pkg::EXHAUSTED);
    assign otp          = lfsr_state;
    assign words_issued = words_q;

endmodule

// File: tb/tb_otp_keystream_gen.sv
// Directed bench: instance 0 has no warm-up and a 4-word budget, instance 1 the
// default 16-step warm-up; expected pad words are hand-computed where practical.
module tb_otp_keystream_gen;
    import otp_pkg::*;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, seed_valid0, seed_ready0, otp_valid0, otp_ready0, rekey0, busy0;
    logic [31:0] seed0, otp0;
    logic [2:0]  words0;

    logic        rst1, seed_valid1, seed_ready1, otp_valid1, otp_ready1, rekey1, busy1;
    logic [31:0] seed1, otp1;
    logic [10:0] words1;

    logic [63:0] model;

    otp_keystream_gen #(.WARMUP(0), .REKEY_LIMIT(4)) u_dut0 (
        .clk(clk), .rst(rst0), .seed_valid(seed_valid0), .seed(seed0),
        .seed_ready(seed_ready0), .otp_valid(otp_valid0), .otp_ready(otp_ready0),
        .otp(otp0), .words_issued(words0), .rekey_req(rekey0), .busy(busy0)
    );

    otp_keystream_gen #(.WARMUP(16)) u_dut1 (
        .clk(clk), .rst(rst1), .seed_valid(seed_valid1), .seed(seed1),
        .seed_ready(seed_ready1), .otp_valid(otp_valid1), .otp_ready(otp_ready1),
        .otp(otp1), .words_issued(words1), .rekey_req(rekey1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_seed_ready"}, 64'(seed_ready0), 64'd1);
        chk({tag, "_otp_valid"},  64'(otp_valid0),  64'd0);
        chk({tag, "_otp"},        64'(otp0),        64'd0);
        chk({tag, "_words"},      64'(words0),      64'd0);
        chk({tag, "_rekey"},      64'(rekey0),      64'd0);
        chk({tag, "_busy"},       64'(busy0),       64'd0);
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_seed_ready"}, 64'(seed_ready1), 64'd1);
        chk({tag, "_otp_valid"},  64'(otp_valid1),  64'd0);
        chk({tag, "_otp"},        64'(otp1),        64'd0);
        chk({tag, "_words"},      64'(words1),      64'd0);
        chk({tag, "_rekey"},      64'(rekey1),      64'd0);
        chk({tag, "_busy"},       64'(busy1),       64'd0);
    endtask

    initial begin
        rst0 = 1'b1; seed_valid0 = 1'b0; seed0 = '0; otp_ready0 = 1'b0;
        rst1 = 1'b1; seed_valid1 = 1'b0; seed1 = '0; otp_ready1 = 1'b0;
        tick();
        tick();
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        chk_reset0("reset0");
        chk_reset1("reset1");

        // basic sequence, seed 1, no warm-up
        seed_valid0 = 1'b1; seed0 = 32'h0000_0001; otp_ready0 = 1'b1;
        tick();
        seed_valid0 = 1'b0;
        chk("seq_w0_otp",   64'(otp0),        64'h0000_0001);
        chk("seq_w0_valid", 64'(otp_valid0),  64'd1);
        chk("seq_w0_words", 64'(words0),      64'd0);
        chk("seq_w0_sready",64'(seed_ready0), 64'd0);
        tick();
        chk("seq_w1_otp",   64'(otp0),   64'h8020_0003);
        chk("seq_w1_words", 64'(words0), 64'd1);

        // backpressure with an ignored seed offer during RUN
        otp_ready0 = 1'b0; seed_valid0 = 1'b1; seed0 = 32'h0000_DEAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_otp",    64'(otp0),        64'h8020_0003);
            chk("bp_words",  64'(words0),      64'd1);
            chk("bp_valid",  64'(otp_valid0),  64'd1);
            chk("bp_sready", 64'(seed_ready0), 64'd0);
        end
        seed_valid0 = 1'b0; otp_ready0 = 1'b1;
        tick();
        chk("seq_w2_otp",   64'(otp0),   64'hC030_0002);
        chk("seq_w2_words", 64'(words0), 64'd2);
        tick();
        chk("seq_w3_otp",   64'(otp0),   64'h6018_0001);
        chk("seq_w3_words", 64'(words0), 64'd3);
        tick();
        chk("exh_valid",  64'(otp_valid0),  64'd0);
        chk("exh_rekey",  64'(rekey0),      64'd1);
        chk("exh_words",  64'(words0),      64'd4);
        chk("exh_sready", 64'(seed_ready0), 64'd1);
        tick();
        chk("exh_hold_words", 64'(words0), 64'd4);
        chk("exh_hold_rekey", 64'(rekey0), 64'd1);

        // rekey with a fresh seed
        seed_valid0 = 1'b1; seed0 = 32'h0000_1234;
        tick();
        seed_valid0 = 1'b0;
        chk("rekey_rekey", 64'(rekey0),     64'd0);
        chk("rekey_words", 64'(words0),     64'd0);
        chk("rekey_otp",   64'(otp0),       64'h0000_1234);
        chk("rekey_valid", 64'(otp_valid0), 64'd1);
        tick();
        chk("rekey_next_otp",   64'(otp0),   64'h0000_091A);
        chk("rekey_next_words", 64'(words0), 64'd1);

        // asynchronous reset between edges, mid-RUN
        rst0 = 1'b1;
        #1;
        chk_reset0("arst_run0");
        rst0 = 1'b0;
        tick();
        chk("post_rst0_sready", 64'(seed_ready0), 64'd1);
        chk("post_rst0_valid",  64'(otp_valid0),  64'd0);
        chk("post_rst0_words",  64'(words0),      64'd0);

        // zero seed loads as 1
        seed_valid0 = 1'b1; seed0 = 32'h0000_0000;
        tick();
        seed_valid0 = 1'b0;
        chk("zero_seed_otp",   64'(otp0),       64'h0000_0001);
        chk("zero_seed_valid", 64'(otp_valid0), 64'd1);
        tick();
        chk("zero_seed_next",  64'(otp0),       64'h8020_0003);

        // warm-up latency on the 16-step instance
        model = 64'h0000_ACE1;
        repeat (16) model = lfsr_step(model, 64'h8020_0003);
        seed_valid1 = 1'b1; seed1 = 32'h0000_ACE1; otp_ready1 = 1'b1;
        tick();
        seed_valid1 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            chk("wu_busy",   64'(busy1),       64'd1);
            chk("wu_valid",  64'(otp_valid1),  64'd0);
            chk("wu_sready", 64'(seed_ready1), 64'd0);
        end
        tick();
        chk("wu_done_busy",  64'(busy1),      64'd0);
        chk("wu_done_valid", 64'(otp_valid1), 64'd1);
        chk("wu_done_otp",   64'(otp1),       64'(model[31:0]));
        chk("wu_done_words", 64'(words1),     64'd0);
        model = lfsr_step(model, 64'h8020_0003);
        tick();
        chk("wu_next_otp",   64'(otp1),   64'(model[31:0]));
        chk("wu_next_words", 64'(words1), 64'd1);

        rst1 = 1'b1;
        #1;
        chk_reset1("arst_run1");
        rst1 = 1'b0;
        tick();

        // asynchronous reset between edges, mid-WARMUP
        seed_valid1 = 1'b1; seed1 = 32'h0000_5A5A;
        tick();
        seed_valid1 = 1'b0;
        repeat (4) tick();
        chk("mid_wu_busy", 64'(busy1), 64'd1);
        rst1 = 1'b1;
        #1;
        chk_reset1("arst_wu1");
        rst1 = 1'b0;
        tick();
        chk("post_rst1_sready", 64'(seed_ready1), 64'd1);
        chk("post_rst1_busy",   64'(busy1),       64'd0);
        chk("post_rst1_valid",  64'(otp_valid1),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
